nco_sweep_ctrl: RTL and testbench
=================================

# nco_sweep_ctrl

Carrier-acquisition controller for the receiver NCO. It steps the DDS phase increment from a start value in fixed increments, and delivers each word over the DDS AXI-Stream config channel with a valid/ready handshake. At each step it dwells for a programmed number of cycles while watching the Costas-loop lock indicator. It stops on the first qualified lock and holds that frequency; otherwise it reports failure (or rescans, see Configuration).

## Interface
- PINC_WIDTH, 32, phase-increment width; equals DDS config tdata width
- DWELL_WIDTH, 16, dwell counter width
- STEP_WIDTH, 12, step index width
- LOCK_HOLD, 8, consecutive lock-high cycles required to declare lock (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a sweep; honoured only in IDLE, LOCKED or FAIL
- abort  in  1  return to IDLE; overrides start
- pinc_start  in  PINC_WIDTH  first phase increment
- pinc_step  in  PINC_WIDTH  added per step, modulo 2^PINC_WIDTH
- step_last  in  STEP_WIDTH  index of final step; 0 means a single frequency
- dwell  in  DWELL_WIDTH  cycles per step; 0 is treated as 1
- lock  in  1  loop lock indicator, sampled every cycle
- cfg_tdata  out  PINC_WIDTH  phase increment to DDS config channel
- cfg_tvalid  out  1  config word valid
- cfg_tready  in  1  DDS accepts config word
- busy  out  1  high in LOAD or SETTLE
- locked  out  1  high in LOCKED
- fail  out  1  high in FAIL
- step_idx  out  STEP_WIDTH  current step index

## Operation
- States: IDLE, LOAD, SETTLE, LOCKED, FAIL. All outputs are registered.
- Reset values: state IDLE; cfg_tdata 0; cfg_tvalid 0; busy, locked, fail 0; step_idx 0; all counters 0.
- start pulse: latches pinc_start, pinc_step, step_last and dwell; sets step_idx=0 and cfg_tdata=pinc_start; moves to LOAD.
- LOAD:
  - cfg_tvalid=1; cfg_tdata held stable until cfg_tvalid&cfg_tready.
  - On the handshake: cfg_tvalid→0, dwell counter loaded with max(dwell,1)−1, lock-hold counter cleared, go to SETTLE.
- SETTLE, each cycle:
  - If lock=1, the hold counter increments; if lock=0, it clears.
  - When the hold counter reaches LOCK_HOLD, go to LOCKED. This takes priority over dwell expiry in the same cycle.
  - Otherwise, at dwell counter 0:
    - if step_idx<step_last: step_idx+1, cfg_tdata+=pinc_step (wraps), go to LOAD;
    - else go to FAIL (or wrap, see Configuration).
- LOCKED: cfg_tdata holds the locking word. The state is held regardless of lock; it exits only on start or abort.
- FAIL: holds the last word; exits only on start or abort.
- abort in any state: IDLE next cycle. cfg_tvalid drops even without a handshake; the DDS config channel tolerates this. cfg_tdata keeps its value.
- start outside IDLE/LOCKED/FAIL is ignored.
- Sampling of lock, abort and cfg_tready:
  - lock is ignored outside SETTLE.
  - abort is sampled in the same cycle as any cfg_tready.

## Timing
- start at cycle t: LOAD and cfg_tvalid=1 at t+1.
- Handshake at cycle h: SETTLE covers h+1 … h+D, where D=max(dwell,1).
- Dwell expiry at h+D, no lock: next LOAD with new cfg_tdata at h+D+1. Per-step period is D+1 cycles plus handshake wait.
- lock high from h+1: LOCKED at h+LOCK_HOLD+1, provided LOCK_HOLD≤D.
- Hold count reaching LOCK_HOLD on the expiry cycle: LOCKED wins.
- The DDS has one extra cycle of output delay; the dwell value must absorb it.

## Configuration
- SWEEP_WRAP_EN defined:
  - On final-step expiry, reload step_idx=0 and cfg_tdata=latched pinc_start, then go to LOAD.
  - The sweep repeats until lock or abort; FAIL is unreachable and fail stays 0.
- SWEEP_WRAP_EN undefined: final-step expiry goes to FAIL.

## Structure
- Package nco_ctrl_pkg:
  - state enum (IDLE, LOAD, SETTLE, LOCKED, FAIL);
  - default width constants PINC_WIDTH/DWELL_WIDTH/STEP_WIDTH.
- Sub-module lock_qualifier: consecutive-high counter with inputs clr, lock and outputs qualified. It is cleared on every LOAD→SETTLE transition.

## Test plan
- Three-step sweep, no lock: pinc_start=0x01000000, step=0x00100000, step_last=2, dwell=10, tready=1, lock=0.
  - cfg_tdata handshakes 0x01000000, 0x01100000, 0x01200000, each 11 cycles apart.
  - fail=1 after the third dwell (wrap build: fourth word is 0x01000000 and fail stays 0).
- Lock mid-sweep: same setup, lock=1 from 3 cycles into step 1, LOCK_HOLD=8.
  - locked=1, step_idx=1, cfg_tdata=0x01100000.
  - No further cfg_tvalid.
- Glitchy lock: lock toggling 1,1,1,0 repeatedly in SETTLE with LOCK_HOLD=4. Never locks; the sweep advances normally.
- Backpressure and abort: cfg_tready=0 for 5 cycles.
  - cfg_tvalid and cfg_tdata stay stable; SETTLE starts the cycle after tready rises.
  - abort in LOAD: IDLE and cfg_tvalid=0 next cycle.
- Boundaries:
  - pinc_start=0xFFF00000, step=0x00200000: second word is 0x00100000 (wrap).
  - dwell=0 behaves as dwell=1.
  - step_last=0: exactly one config word.
- Reset mid-SETTLE: rst asserted asynchronously. All outputs return to reset values immediately; start after release begins a fresh sweep.

Source files
------------

// File: rtl/nco_ctrl_pkg.sv
// Shared types and default widths for the NCO carrier-acquisition sweep controller.
package nco_ctrl_pkg;

  localparam int PINC_WIDTH  = 32;
  localparam int DWELL_WIDTH = 16;
  localparam int STEP_WIDTH  = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    LOCKED = 3'd3,
    FAIL   = 3'd4
  } state_t;

endpackage

// File: rtl/lock_qualifier.sv
// Counts consecutive lock-high cycles; qualified fires on the cycle the run reaches LOCK_HOLD.
module lock_qualifier #(
  parameter int LOCK_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic lock,
  output logic qualified
);

  localparam int CW = $clog2(LOCK_HOLD + 1);

  logic [CW-1:0] cnt;

  // Qualify on the cycle that would bring the count to LOCK_HOLD, so the
  // controller leaves SETTLE exactly LOCK_HOLD cycles after lock rises.
  assign qualified = lock && (cnt == CW'(LOCK_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || !lock) begin
      cnt <= '0;
    end else if (!qualified) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Steps the DDS phase increment and dwells per step until the Costas loop locks.
// Build option: define SWEEP_WRAP_EN to rescan from pinc_start instead of reporting fail.
module nco_sweep_ctrl #(
  parameter int PINC_WIDTH  = nco_ctrl_pkg::PINC_WIDTH,
  parameter int DWELL_WIDTH = nco_ctrl_pkg::DWELL_WIDTH,
  parameter int STEP_WIDTH  = nco_ctrl_pkg::STEP_WIDTH,
  parameter int LOCK_HOLD   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PINC_WIDTH-1:0]  pinc_start,
  input  logic [PINC_WIDTH-1:0]  pinc_step,
  input  logic [STEP_WIDTH-1:0]  step_last,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic                   lock,
  output logic [PINC_WIDTH-1:0]  cfg_tdata,
  output logic                   cfg_tvalid,
  input  logic                   cfg_tready,
  output logic                   busy,
  output logic                   locked,
  output logic                   fail,
  output logic [STEP_WIDTH-1:0]  step_idx,
  output logic [2:0]             state_dbg
);

  import nco_ctrl_pkg::*;

  state_t                 state;
  logic [PINC_WIDTH-1:0]  pinc_start_q;
  logic [PINC_WIDTH-1:0]  pinc_step_q;
  logic [STEP_WIDTH-1:0]  step_last_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic [DWELL_WIDTH-1:0] dwell_cnt;
  logic                   handshake;
  logic                   hold_clr;
  logic                   hold_lock;
  logic                   qualified;

  // Config channel: a word transfers on a cycle with cfg_tvalid && cfg_tready;
  // cfg_tdata is stable while cfg_tvalid waits, and abort may withdraw cfg_tvalid.
  assign handshake = (state == LOAD) && cfg_tvalid && cfg_tready;
  assign hold_clr  = handshake && !abort;
  assign hold_lock = lock && (state == SETTLE);
  assign state_dbg = state;

  lock_qualifier #(.LOCK_HOLD(LOCK_HOLD)) u_lock_qualifier (
    .clk       (clk),
    .rst       (rst),
    .clr       (hold_clr),
    .lock      (hold_lock),
    .qualified (qualified)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cfg_tdata    <= '0;
      cfg_tvalid   <= 1'b0;
      busy         <= 1'b0;
      locked       <= 1'b0;
      fail         <= 1'b0;
      step_idx     <= '0;
      pinc_start_q <= '0;
      pinc_step_q  <= '0;
      step_last_q  <= '0;
      dwell_q      <= '0;
      dwell_cnt    <= '0;
    end else if (abort) begin
      state      <= IDLE;
      cfg_tvalid <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      case (state)
        IDLE, LOCKED, FAIL: begin
          if (start) begin
            pinc_start_q <= pinc_start;
            pinc_step_q  <= pinc_step;
            step_last_q  <= step_last;
            dwell_q      <= dwell;
            step_idx     <= '0;
            cfg_tdata    <= pinc_start;
            cfg_tvalid   <= 1'b1;
            busy         <= 1'b1;
            locked       <= 1'b0;
            fail         <= 1'b0;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (cfg_tready) begin
            cfg_tvalid <= 1'b0;
            dwell_cnt  <= (dwell_q == '0) ? '0 : dwell_q - DWELL_WIDTH'(1);
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (qualified) begin
            busy   <= 1'b0;
            locked <= 1'b1;
            state  <= LOCKED;
          end else if (dwell_cnt == '0) begin
            if (step_idx < step_last_q) begin
              step_idx   <= step_idx + STEP_WIDTH'(1);
              cfg_tdata  <= cfg_tdata + pinc_step_q;
              cfg_tvalid <= 1'b1;
              state      <= LOAD;
            end else begin
`ifdef SWEEP_WRAP_EN
              step_idx   <= '0;
              cfg_tdata  <= pinc_start_q;
              cfg_tvalid <= 1'b1;
              state      <= LOAD;
`else
              busy  <= 1'b0;
              fail  <= 1'b1;
              state <= FAIL;
`endif
            end
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed sweeps plus randomized sweeps against a step-level timing model.
module tb_nco_sweep_ctrl;

  localparam int LH = 4;
  localparam int W  = 100;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] pinc_start = '0;
  logic [31:0] pinc_step = '0;
  logic [11:0] step_last = '0;
  logic [15:0] dwell = '0;
  logic        lock = 1'b0;
  logic        cfg_tready = 1'b0;
  logic [31:0] cfg_tdata;
  logic        cfg_tvalid;
  logic        busy;
  logic        locked;
  logic        fail;
  logic [11:0] step_idx;
  logic [2:0]  state_dbg;

  nco_sweep_ctrl #(
    .PINC_WIDTH(32), .DWELL_WIDTH(16), .STEP_WIDTH(12), .LOCK_HOLD(LH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pinc_start(pinc_start), .pinc_step(pinc_step), .step_last(step_last),
    .dwell(dwell), .lock(lock), .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid),
    .cfg_tready(cfg_tready), .busy(busy), .locked(locked), .fail(fail),
    .step_idx(step_idx), .state_dbg(state_dbg)
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int          exp_t_q[$];
  int          exp_i_q[$];
  logic [31:0] obs_q[$];
  int          obs_t_q[$];
  int          obs_i_q[$];
  bit          rdy[W];
  bit          lk[W];
  logic        e_busy, e_lock, e_fail, e_valid;
  logic [31:0] e_data;
  int          e_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step-level model: per step, find the handshake cycle, scan the dwell window for a
  // run of LH lock-high cycles, else advance/terminate. Cycle 0 is the start cycle.
  task automatic model(input logic [31:0] ps, input logic [31:0] st, input int last, input int dw);
    int cur, h, d, run, idx;
    logic [31:0] word;
    bit done, hit;
    exp_q.delete(); exp_t_q.delete(); exp_i_q.delete();
    d = (dw == 0) ? 1 : dw;
    cur = 1; idx = 0; word = ps; done = 0;
    e_busy = 1; e_lock = 0; e_fail = 0; e_valid = 1;
    while (!done) begin
      e_idx = idx; e_data = word;
      h = -1;
      for (int k = cur; k < W; k++) if (rdy[k]) begin h = k; break; end
      if (h < 0) begin
        e_valid = 1; done = 1;
      end else begin
        exp_q.push_back(word); exp_t_q.push_back(h); exp_i_q.push_back(idx);
        e_valid = 0; run = 0; hit = 0;
        for (int k = h + 1; k <= h + d; k++) begin
          if (k >= W - 1) begin done = 1; break; end
          run = lk[k] ? run + 1 : 0;
          if (run == LH) begin hit = 1; break; end
        end
        if (hit) begin
          e_busy = 0; e_lock = 1; done = 1;
        end else if (!done) begin
          cur = h + d + 1;
          if (idx < last) begin
            idx++; word = word + st;
          end else begin
`ifdef SWEEP_WRAP_EN
            idx = 0; word = ps;
`else
            e_busy = 0; e_fail = 1; done = 1;
`endif
          end
        end
      end
    end
  endtask

  // driver: abort to IDLE, start a sweep, play rdy/lk for W cycles, compare with model
  task automatic run_sweep(input string name, input logic [31:0] ps, input logic [31:0] st,
                           input int last, input int dw);
    obs_q.delete(); obs_t_q.delete(); obs_i_q.delete();
    abort = 1'b1; tick(); abort = 1'b0;
    start = 1'b1; pinc_start = ps; pinc_step = st;
    step_last = 12'(last); dwell = 16'(dw);
    cfg_tready = rdy[0]; lock = lk[0];
    for (int k = 1; k < W; k++) begin
      tick();
      if (k == 1) begin
        start = 1'b0; pinc_start = $urandom; pinc_step = $urandom;
        step_last = 12'($urandom_range(0, 7)); dwell = 16'($urandom_range(0, 20));
      end
      cfg_tready = rdy[k]; lock = lk[k];
      if (cfg_tvalid && cfg_tready) begin
        obs_q.push_back(cfg_tdata); obs_t_q.push_back(k); obs_i_q.push_back(int'(step_idx));
      end
    end
    model(ps, st, last, dw);
    check({name, "_hs_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_word%0d", name, i), 64'(obs_q[i]), 64'(exp_q[i]));
      check($sformatf("%s_time%0d", name, i), 64'(obs_t_q[i]), 64'(exp_t_q[i]));
      check($sformatf("%s_idx%0d", name, i), 64'(obs_i_q[i]), 64'(exp_i_q[i]));
    end
    check({name, "_busy"}, 64'(busy), 64'(e_busy));
    check({name, "_locked"}, 64'(locked), 64'(e_lock));
    check({name, "_fail"}, 64'(fail), 64'(e_fail));
    check({name, "_tvalid"}, 64'(cfg_tvalid), 64'(e_valid));
    check({name, "_tdata"}, 64'(cfg_tdata), 64'(e_data));
    check({name, "_step_idx"}, 64'(step_idx), 64'(e_idx));
  endtask

  task automatic fill(input int rmode, input int lmode, input int k0);
    for (int k = 0; k < W; k++) begin
      case (rmode)
        0: rdy[k] = 1'b1;
        1: rdy[k] = (k > k0);
        default: rdy[k] = ($urandom_range(0, 1) == 1);
      endcase
      case (lmode)
        0: lk[k] = 1'b0;
        1: lk[k] = ((k + k0) % 4) != 3;
        2: lk[k] = (k >= k0);
        default: lk[k] = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  initial begin
    // reset state
    tick(); tick();
    check("rst_tvalid", 64'(cfg_tvalid), 64'(0));
    check("rst_tdata", 64'(cfg_tdata), 64'(0));
    check("rst_flags", 64'({busy, locked, fail}), 64'(0));
    check("rst_step_idx", 64'(step_idx), 64'(0));
    rst = 1'b0;
    tick();

    // three-step sweep, no lock
    fill(0, 0, 0);
    run_sweep("sweep3", 32'h0100_0000, 32'h0010_0000, 2, 10);
    if (obs_q.size() >= 3) begin
      check("sweep3_w0", 64'(obs_q[0]), 64'h0100_0000);
      check("sweep3_w1", 64'(obs_q[1]), 64'h0110_0000);
      check("sweep3_w2", 64'(obs_q[2]), 64'h0120_0000);
      check("sweep3_gap", 64'(obs_t_q[2] - obs_t_q[1]), 64'(11));
`ifdef SWEEP_WRAP_EN
      if (obs_q.size() >= 4) check("sweep3_wrap_w3", 64'(obs_q[3]), 64'h0100_0000);
      else check("sweep3_wrap_count", 64'(obs_q.size()), 64'(4));
      check("sweep3_wrap_fail", 64'(fail), 64'(0));
`else
      check("sweep3_fail", 64'(fail), 64'(1));
`endif
    end else check("sweep3_count", 64'(obs_q.size()), 64'(3));

    // lock from 3 cycles into step 1 (step 1 handshake at cycle 12, SETTLE from 13)
    fill(0, 2, 15);
    run_sweep("midlock", 32'h0100_0000, 32'h0010_0000, 2, 10);
    check("midlock_locked", 64'(locked), 64'(1));
    check("midlock_idx", 64'(step_idx), 64'(1));
    check("midlock_data", 64'(cfg_tdata), 64'h0110_0000);
    check("midlock_words", 64'(obs_q.size()), 64'(2));

    // glitchy lock never qualifies
    fill(0, 1, 1);
    run_sweep("glitch", 32'h0200_0000, 32'h0001_0000, 3, 6);
    check("glitch_locked", 64'(locked), 64'(0));

    // backpressure: tready low for cycles 1..5
    fill(1, 0, 5);
    run_sweep("bp", 32'h1234_5678, 32'h0000_1000, 1, 4);
    if (obs_t_q.size() >= 1) check("bp_first_hs", 64'(obs_t_q[0]), 64'(6));
    else check("bp_count", 64'(obs_q.size()), 64'(2));

    // wrapping increment, dwell 0, single step
    fill(0, 0, 0);
    run_sweep("pwrap", 32'hFFF0_0000, 32'h0020_0000, 1, 3);
    if (obs_q.size() >= 2) check("pwrap_w1", 64'(obs_q[1]), 64'h0010_0000);
    else check("pwrap_count", 64'(obs_q.size()), 64'(2));
    run_sweep("dwell0", 32'h0000_0100, 32'h0000_0010, 1, 0);
    if (obs_t_q.size() >= 2) check("dwell0_gap", 64'(obs_t_q[1] - obs_t_q[0]), 64'(2));
    else check("dwell0_count", 64'(obs_q.size()), 64'(2));
    run_sweep("single", 32'h0ABC_0000, 32'h0000_0001, 0, 5);
`ifndef SWEEP_WRAP_EN
    check("single_words", 64'(obs_q.size()), 64'(1));
`endif

    // randomized sweeps
    for (int s = 0; s < 16; s++) begin
      fill($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 40));
      run_sweep($sformatf("rnd%0d", s), $urandom, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 12));
    end

    // backpressure hold, ignored start while busy, abort in LOAD
    abort = 1'b1; tick(); abort = 1'b0;
    cfg_tready = 1'b0; lock = 1'b0;
    start = 1'b1; pinc_start = 32'hA5A5_0000; tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin start = 1'b1; pinc_start = 32'h1111_1111; end
      else start = 1'b0;
      check($sformatf("bp_hold_valid%0d", i), 64'(cfg_tvalid), 64'(1));
      check($sformatf("bp_hold_data%0d", i), 64'(cfg_tdata), 64'hA5A5_0000);
      tick();
    end
    start = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_tvalid", 64'(cfg_tvalid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_tdata", 64'(cfg_tdata), 64'hA5A5_0000);

    // asynchronous reset mid-SETTLE, then a fresh sweep
    cfg_tready = 1'b1; dwell = 16'd10; step_last = 12'd2;
    start = 1'b1; pinc_start = 32'h0300_0000; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_busy", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_tdata", 64'(cfg_tdata), 64'(0));
    check("arst_flags", 64'({cfg_tvalid, busy, locked, fail}), 64'(0));
    check("arst_step_idx", 64'(step_idx), 64'(0));
    tick(); rst = 1'b0;
    start = 1'b1; pinc_start = 32'h0400_0000; tick(); start = 1'b0;
    check("post_rst_tvalid", 64'(cfg_tvalid), 64'(1));
    check("post_rst_tdata", 64'(cfg_tdata), 64'h0400_0000);
    check("post_rst_busy", 64'(busy), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
